// File: rtl/aes_start_ctrl_if.sv
// Valid/ready handshake between the AES start controller and the cipher core.
// master: controller side (drives in_valid, out_ready); slave: core side.
interface aes_start_ctrl_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;

    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid
    );
endinterface

// File: rtl/aes_start_ctrl.sv
// AES start/handshake controller: tracks data/key writes and output reads,
// starts blocks (auto or manual), drives core handshake, drains on clear.
// Ports: clk_i, rst_i (sync, active-high); data_in_we_i, key_we_i,
//   data_out_re_i strobes; manual_op_i, start_i, clear_i controls;
//   core (handshake to cipher core); data_in_new_o, key_clean_o,
//   output_valid_o, stall_o, idle_o status.
module aes_start_ctrl #(
    parameter int NumWords = 4,
    parameter int KeyWords = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumWords-1:0] data_in_we_i,
    input  logic [KeyWords-1:0] key_we_i,
    input  logic [NumWords-1:0] data_out_re_i,
    input  logic                manual_op_i,
    input  logic                start_i,
    input  logic                clear_i,
    aes_start_ctrl_if.master    core,
    output logic                data_in_new_o,
    output logic                key_clean_o,
    output logic                output_valid_o,
    output logic                stall_o,
    output logic                idle_o
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BUSY,
        DRAIN
    } state_e;

    state_e state_q, state_d;

    logic [NumWords-1:0] in_mask_q, in_mask_d;
    logic [KeyWords-1:0] key_mask_q, key_mask_d;
    logic [NumWords-1:0] rd_mask_q, rd_mask_d;
    logic                data_new_q, data_new_d;
    logic                key_clean_q, key_clean_d;
    logic                out_valid_q, out_valid_d;
    logic                in_valid_q, in_valid_d;
    logic                idle_q, idle_d;

    logic consume;
    logic accept;
    logic out_ready;
    logic rd_done;

    // Output registers become fully read in this cycle.
    assign rd_done = out_valid_q & (&(rd_mask_q | data_out_re_i));

    always_comb begin
        state_d   = state_q;
        consume   = 1'b0;
        accept    = 1'b0;
        out_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!clear_i && data_new_q && key_clean_q &&
                    (!manual_op_i || start_i)) begin
                    consume = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (clear_i) begin
                    // Block already handed over must be drained.
                    state_d = (in_valid_q && core.in_ready) ? DRAIN : IDLE;
                end else if (in_valid_q && core.in_ready) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                out_ready = !out_valid_q || rd_done;
                accept    = core.out_valid && out_ready;
                // An accept in the clear cycle ends the op; only the
                // stored result is wiped.
                if (accept) begin
                    state_d = IDLE;
                end else if (clear_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                out_ready = 1'b1;
                if (core.out_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // Input tracker: clear/consume wins over coincident writes.
        if (clear_i || consume) begin
            in_mask_d = '0;
        end else begin
            in_mask_d = in_mask_q | data_in_we_i;
        end
        data_new_d = &in_mask_d;

        // Key tracker: a write after a complete key restarts tracking.
        if (clear_i) begin
            key_mask_d = '0;
        end else if (key_clean_q && |key_we_i) begin
            key_mask_d = key_we_i;
        end else begin
            key_mask_d = key_mask_q | key_we_i;
        end
        key_clean_d = &key_mask_d;

        // Output tracker.
        out_valid_d = out_valid_q;
        rd_mask_d   = rd_mask_q;
        if (clear_i) begin
            out_valid_d = 1'b0;
            rd_mask_d   = '0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            rd_mask_d   = '0;
        end else if (rd_done) begin
            out_valid_d = 1'b0;
            rd_mask_d   = '0;
        end else if (out_valid_q) begin
            rd_mask_d = rd_mask_q | data_out_re_i;
        end

        in_valid_d = (state_d == LOAD);
        idle_d     = (state_d == IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            in_mask_q   <= '0;
            key_mask_q  <= '0;
            rd_mask_q   <= '0;
            data_new_q  <= 1'b0;
            key_clean_q <= 1'b0;
            out_valid_q <= 1'b0;
            in_valid_q  <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            in_mask_q   <= in_mask_d;
            key_mask_q  <= key_mask_d;
            rd_mask_q   <= rd_mask_d;
            data_new_q  <= data_new_d;
            key_clean_q <= key_clean_d;
            out_valid_q <= out_valid_d;
            in_valid_q  <= in_valid_d;
            idle_q      <= idle_d;
        end
    end

    assign core.in_valid  = in_valid_q;
    assign core.out_ready = out_ready;
    assign data_in_new_o  = data_new_q;
    assign key_clean_o    = key_clean_q;
    assign output_valid_o = out_valid_q;
    assign stall_o        = (state_q == BUSY) && core.out_valid && !out_ready;
    assign idle_o         = idle_q;

endmodule
